cpu_clock_control: RTL and testbench

//  Consumes the divider's clock outputs (clock25Mhz/1Mhz/1Khz/25hz, all registered off `clock`) and issues the

---
 rtl/cpu_clock_control_pkg.sv | 16 +
 rtl/cpu_clock_control_if.sv | 30 +++
 rtl/cpu_clock_control_button_debouncer.sv | 45 ++++
 rtl/cpu_clock_control.sv | 106 ++++++++++
 tb/tb_cpu_clock_control.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_clock_control_pkg.sv
// Shared constants for the AP9 clock-enable block: speed selector codes and FSM states.
package cpu_clock_control_pkg;

  localparam logic [2:0] SPEED_FULL = 3'd0;
  localparam logic [2:0] SPEED_25M  = 3'd1;
  localparam logic [2:0] SPEED_1M   = 3'd2;
  localparam logic [2:0] SPEED_1K   = 3'd3;
  localparam logic [2:0] SPEED_25HZ = 3'd4;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_t;

endpackage

// File: rtl/cpu_clock_control_if.sv
// Divider taps, run controls and clock-enable outputs between clock_divider, the core and cpu_clock_control.
interface cpu_clock_control_if #(
  parameter int CNT_W = 32
) ();

  logic             clock25Mhz;
  logic             clock1Mhz;
  logic             clock1Khz;
  logic             clock25hz;
  logic [2:0]       speed_sel;
  logic             step_button;
  logic             halt_request;
  logic             run_request;
  logic             cpu_ce;
  logic             halted;
  logic [CNT_W-1:0] ce_count;

  modport master (
    output clock25Mhz, clock1Mhz, clock1Khz, clock25hz,
    output speed_sel, step_button, halt_request, run_request,
    input  cpu_ce, halted, ce_count
  );

  modport slave (
    input  clock25Mhz, clock1Mhz, clock1Khz, clock25hz,
    input  speed_sel, step_button, halt_request, run_request,
    output cpu_ce, halted, ce_count
  );

endinterface

// File: rtl/cpu_clock_control_button_debouncer.sv
// Step push-button conditioning: 2-flop synchroniser, tick-counted debounce and a one-cycle press pulse.
module button_debouncer #(
  parameter int DEBOUNCE_MS = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic stable,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_MS + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      press  <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      // Any cycle where the input agrees with the accepted level restarts the count.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CW'(DEBOUNCE_MS - 1)) begin
          stable <= sync2;
          press  <= sync2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/cpu_clock_control.sv
// Core clock-enable generator: divider edge detect, speed mux, run/halt/step FSM and enable counter.
module cpu_clock_control
  import cpu_clock_control_pkg::*;
#(
  parameter int DEBOUNCE_MS  = 5,
  parameter bit START_HALTED = 1'b0,
  parameter int CNT_W        = 32
) (
  input logic               clock,
  input logic               reset,
  cpu_clock_control_if.slave bus
);

  localparam state_t RESET_STATE = START_HALTED ? ST_HALT : ST_RUN;

  logic [3:0]       div_in;
  logic [3:0]       div_prev;
  logic [3:0]       div_tick;
  logic [2:0]       sel_q;
  logic             sel_tick;
  logic             step_press;
  state_t           state_q;
  state_t           state_next;
  logic             ce_next;
  logic             cpu_ce_q;
  logic             halted_q;
  logic [CNT_W-1:0] count_q;

  assign div_in = {bus.clock25hz, bus.clock1Khz, bus.clock1Mhz, bus.clock25Mhz};

  // History resets high like the divider outputs, so leaving reset never looks like a rising edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_prev <= '1;
      sel_q    <= SPEED_FULL;
    end else begin
      div_prev <= div_in;
      sel_q    <= bus.speed_sel;
    end
  end

  assign div_tick = div_in & ~div_prev;

  always_comb begin
    sel_tick = 1'b0;
    case (sel_q)
      SPEED_FULL: sel_tick = 1'b1;
      SPEED_25M:  sel_tick = div_tick[0];
      SPEED_1M:   sel_tick = div_tick[1];
      SPEED_1K:   sel_tick = div_tick[2];
      SPEED_25HZ: sel_tick = div_tick[3];
      default:    sel_tick = 1'b0;
    endcase
  end

  button_debouncer #(
    .DEBOUNCE_MS(DEBOUNCE_MS)
  ) u_debouncer (
    .clock (clock),
    .reset (reset),
    .tick  (div_tick[2]),
    .raw   (bus.step_button),
    .stable(),
    .press (step_press)
  );

  always_comb begin
    state_next = state_q;
    ce_next    = 1'b0;
    case (state_q)
      ST_RUN: begin
        ce_next = sel_tick & ~bus.halt_request;
        if (bus.halt_request) state_next = ST_HALT;
      end
      ST_HALT: begin
        if (bus.halt_request)     state_next = ST_HALT;
        else if (bus.run_request) state_next = ST_RUN;
        else if (step_press)      state_next = ST_STEP;
      end
      ST_STEP: begin
        ce_next    = 1'b1;
        state_next = ST_HALT;
      end
      default: state_next = RESET_STATE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= RESET_STATE;
      cpu_ce_q <= 1'b0;
      halted_q <= START_HALTED;
      count_q  <= '0;
    end else begin
      state_q  <= state_next;
      cpu_ce_q <= ce_next;
      halted_q <= (state_next != ST_RUN);
      if (cpu_ce_q) count_q <= count_q + CNT_W'(1);
    end
  end

  assign bus.cpu_ce   = cpu_ce_q;
  assign bus.halted   = halted_q;
  assign bus.ce_count = count_q;

endmodule

// File: tb/tb_cpu_clock_control.sv
// Scoreboard bench for cpu_clock_control with a scaled divider model (1 kHz tap = 40 clocks).
module tb_cpu_clock_control;

  localparam int P_CE      = 0;
  localparam int P_HALTED  = 1;
  localparam int P_CNT     = 2;
  localparam int P_CNT4    = 3;
  localparam int P_HALTED4 = 4;
  localparam int P_STABLE  = 5;
  localparam int P_DCNT    = 6;
  localparam int P_CE4     = 7;

  typedef struct {int cyc; int cnt;} ce_exp_t;
  typedef struct {int cyc; int sig; int val;} probe_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   d = 0;
  int   checks = 0;
  int   failures = 0;
  bit   done = 1'b0;
  int   R = 0;
  int   ecnt = 0;

  ce_exp_t sb[$];
  probe_t  pq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) d <= rst ? 0 : d + 1;

  cpu_clock_control_if #(.CNT_W(32)) bus ();
  cpu_clock_control_if #(.CNT_W(4))  bus4 ();

  assign bus.clock25Mhz = (d % 2) == 0;
  assign bus.clock1Mhz  = (d % 8) < 4;
  assign bus.clock1Khz  = (d % 40) < 20;
  assign bus.clock25hz  = (d % 160) < 80;

  assign bus4.clock25Mhz   = bus.clock25Mhz;
  assign bus4.clock1Mhz    = bus.clock1Mhz;
  assign bus4.clock1Khz    = bus.clock1Khz;
  assign bus4.clock25hz    = bus.clock25hz;
  assign bus4.speed_sel    = 3'd0;
  assign bus4.step_button  = 1'b0;
  assign bus4.halt_request = 1'b0;
  assign bus4.run_request  = 1'b1;

  cpu_clock_control #(
    .DEBOUNCE_MS (5),
    .START_HALTED(1'b0),
    .CNT_W       (32)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  cpu_clock_control #(
    .DEBOUNCE_MS (5),
    .START_HALTED(1'b1),
    .CNT_W       (4)
  ) dut4 (
    .clock(clk),
    .reset(rst),
    .bus  (bus4)
  );

  function automatic int actual(input int s);
    case (s)
      P_CE:      return int'(bus.cpu_ce);
      P_HALTED:  return int'(bus.halted);
      P_CNT:     return int'(bus.ce_count);
      P_CNT4:    return int'(bus4.ce_count);
      P_HALTED4: return int'(bus4.halted);
      P_STABLE:  return int'(dut.u_debouncer.stable);
      P_DCNT:    return int'(dut.u_debouncer.cnt);
      P_CE4:     return int'(bus4.cpu_ce);
      default:   return -1;
    endcase
  endfunction

  function automatic string pname(input int s);
    case (s)
      P_CE:      return "cpu_ce";
      P_HALTED:  return "halted";
      P_CNT:     return "ce_count";
      P_CNT4:    return "ce_count_w4";
      P_HALTED4: return "halted_start_halted";
      P_STABLE:  return "stable_q";
      P_DCNT:    return "debounce_cnt";
      P_CE4:     return "cpu_ce_w4";
      default:   return "unknown";
    endcase
  endfunction

  // Monitor: matches every cpu_ce pulse against the scoreboard and evaluates queued probes.
  always @(negedge clk) begin
    ce_exp_t e;
    probe_t  p;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      checks++;
      failures++;
      $display("FAIL ce_missing cyc=%0d got=0 required_pulse_at=%0d", cyc, e.cyc);
    end
    if (bus.cpu_ce === 1'b1) begin
      checks++;
      if (sb.size() == 0 || sb[0].cyc != cyc) begin
        failures++;
        $display("FAIL ce_unexpected cyc=%0d got=1 required=0", cyc);
      end else begin
        e = sb.pop_front();
        checks++;
        if (int'(bus.ce_count) != e.cnt) begin
          failures++;
          $display("FAIL ce_count_at_pulse cyc=%0d got=%0d required=%0d", cyc, bus.ce_count, e.cnt);
        end
      end
    end
    while (pq.size() > 0 && pq[0].cyc <= cyc) begin
      p = pq.pop_front();
      checks++;
      if (p.cyc != cyc || actual(p.sig) != p.val) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%0d required=%0d", pname(p.sig), cyc, actual(p.sig), p.val);
      end
    end
    if (done) begin
      checks++;
      if (sb.size() != 0 || pq.size() != 0) begin
        failures++;
        $display("FAIL leftover got=%0d pending required=0", sb.size() + pq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) step();
  endtask

  task automatic probe(input int s, input int v);
    pq.push_back('{cyc, s, v});
  endtask

  task automatic push_ce(input int c);
    sb.push_back('{c, ecnt});
    ecnt++;
  endtask

  // Press held from cycle b: sync2 high at b+2, fifth 1 kHz tick after that, then press, STEP, cpu_ce.
  function automatic int step_pulse_cycle(input int b);
    int off;
    int t1;
    off = b + 2 - R;
    t1  = R + ((off + 39) / 40) * 40;
    if (t1 <= R) t1 = R + 40;
    return t1 + 163;
  endfunction

  initial begin
    int b;
    int p;
    bus.speed_sel    = 3'd0;
    bus.step_button  = 1'b0;
    bus.halt_request = 1'b0;
    bus.run_request  = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    R = cyc;
    ecnt = 0;

    // Reset state, then full-speed run
    probe(P_CE, 0); probe(P_CNT, 0); probe(P_HALTED, 0);
    probe(P_HALTED4, 1); probe(P_CE4, 0);
    for (int k = 1; k <= 101; k++) push_ce(R + k);
    goto_cyc(R + 1);  probe(P_HALTED4, 0); probe(P_CE4, 0);
    goto_cyc(R + 17); probe(P_CNT4, 15);
    goto_cyc(R + 18); probe(P_CNT4, 0); probe(P_CE4, 1);
    goto_cyc(R + 100); probe(P_CNT, 99);

    // 25 MHz tap, then 1 kHz tap, then no free-run ticks
    bus.speed_sel = 3'd1;
    for (int k = 103; k <= 111; k += 2) push_ce(R + k);
    goto_cyc(R + 110);
    bus.speed_sel = 3'd3;
    push_ce(R + 121); push_ce(R + 161); push_ce(R + 201);
    goto_cyc(R + 220);
    bus.speed_sel = 3'd5;
    goto_cyc(R + 320); probe(P_CNT, 109);

    // Halt request, then run+halt together
    bus.speed_sel = 3'd0;
    for (int k = 322; k <= 330; k++) push_ce(R + k);
    goto_cyc(R + 330);
    bus.halt_request = 1'b1;
    step();
    probe(P_HALTED, 1); probe(P_CE, 0);
    bus.run_request = 1'b1;
    goto_cyc(R + 340); probe(P_HALTED, 1);
    bus.run_request  = 1'b0;
    bus.halt_request = 1'b0;
    goto_cyc(R + 345); probe(P_HALTED, 1); probe(P_CNT, 118);

    // Bounced step press while halted, then a clean second press
    for (int i = 0; i < 10; i++) begin
      bus.step_button = ~bus.step_button;
      repeat (8) step();
    end
    b = cyc;
    bus.step_button = 1'b1;
    push_ce(step_pulse_cycle(b));
    repeat (240) step();
    probe(P_HALTED, 1); probe(P_STABLE, 1); probe(P_CNT, ecnt);
    bus.step_button = 1'b0;
    repeat (240) step();
    probe(P_STABLE, 0);
    b = cyc;
    bus.step_button = 1'b1;
    push_ce(step_pulse_cycle(b));
    repeat (240) step();
    bus.step_button = 1'b0;
    repeat (240) step();
    probe(P_CNT, ecnt);

    // Step press while running is dropped
    bus.speed_sel = 3'd5;
    step();
    bus.run_request = 1'b1;
    step();
    bus.run_request = 1'b0;
    probe(P_HALTED, 0);
    bus.step_button = 1'b1;
    repeat (240) step();
    probe(P_STABLE, 1);
    bus.step_button = 1'b0;
    repeat (240) step();
    bus.halt_request = 1'b1;
    step();
    bus.halt_request = 1'b0;
    probe(P_HALTED, 1);
    repeat (300) step();
    probe(P_CNT, ecnt);

    // Reset while in STEP: the pending pulse must vanish
    b = cyc;
    bus.step_button = 1'b1;
    p = step_pulse_cycle(b);
    goto_cyc(p - 1);
    probe(P_HALTED, 1);
    rst = 1'b1;
    bus.step_button = 1'b0;
    step();
    probe(P_CE, 0); probe(P_CNT, 0); probe(P_HALTED, 0); probe(P_STABLE, 0); probe(P_DCNT, 0);
    step(); step();
    rst = 1'b0;
    R = cyc;
    ecnt = 0;
    probe(P_HALTED, 0);
    push_ce(R + 1);

    // Reset in the middle of a debounce count
    goto_cyc(R + 5);
    bus.halt_request = 1'b1;
    step();
    bus.halt_request = 1'b0;
    probe(P_HALTED, 1);
    b = cyc;
    bus.step_button = 1'b1;
    p = step_pulse_cycle(b) - 163;
    goto_cyc(p + 81);
    probe(P_DCNT, 3);
    rst = 1'b1;
    bus.step_button = 1'b0;
    step();
    probe(P_STABLE, 0); probe(P_DCNT, 0); probe(P_HALTED, 0); probe(P_CE, 0); probe(P_CNT, 0);
    step();
    rst = 1'b0;
    R = cyc;
    ecnt = 0;
    push_ce(R + 1);
    repeat (20) step();
    probe(P_HALTED, 0); probe(P_CNT, 1);
    repeat (3) step();
    done = 1'b1;
    repeat (10) step();
    $display("FAIL end_of_test got=no_summary required=summary");
    $fatal(1);
  end

endmodule
